// File: rtl/history.sv
// Guess history store for a code-breaking game.
// Commits guesses in play mode and lets the player browse past turns.
module history #(
  parameter int MAX_TURNS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic [2:0] guess0,
  input  logic [2:0] guess1,
  input  logic [2:0] guess2,
  input  logic [2:0] guess3,
  output logic [2:0] selection0,
  output logic [2:0] selection1,
  output logic [2:0] selection2,
  output logic [2:0] selection3,
  output logic [2:0] selected_turn,
  output logic       last_turn
);

  localparam logic [3:0] LP_MAX = 4'(MAX_TURNS);

  logic [11:0] r_entry [MAX_TURNS];
  logic [3:0]  r_count;
  logic [2:0]  r_cursor;
  logic        r_up_q;
  logic        r_dn_q;
  logic        r_sel_q;
  logic        r_mode_q;

  logic        w_up_e;
  logic        w_dn_e;
  logic        w_sel_e;
  logic        w_full;
  logic        w_commit;
  logic        w_mode_fall;
  logic [2:0]  w_newest;
  logic        w_can_up;
  logic        w_can_dn;
  logic [11:0] w_rd;

  assign w_up_e      = btn_up & ~r_up_q;
  assign w_dn_e      = btn_down & ~r_dn_q;
  assign w_sel_e     = btn_select & ~r_sel_q;
  assign w_full      = (r_count == LP_MAX);
  assign w_commit    = w_sel_e & ~mode & ~w_full;
  assign w_mode_fall = r_mode_q & ~mode;

  // Index of the newest entry; 0 doubles as the empty-history cursor.
  assign w_newest = (r_count == 4'd0) ? 3'd0 : 3'(r_count - 4'd1);
  assign w_can_up = (r_cursor < w_newest);
  assign w_can_dn = (r_cursor != 3'd0);

  assign w_rd = (r_count == 4'd0) ? 12'd0 : r_entry[r_cursor];

  assign selection0    = w_rd[11:9];
  assign selection1    = w_rd[8:6];
  assign selection2    = w_rd[5:3];
  assign selection3    = w_rd[2:0];
  assign selected_turn = r_cursor;
  assign last_turn     = w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_TURNS; i++) begin
        r_entry[i] <= 12'd0;
      end
      r_count  <= 4'd0;
      r_cursor <= 3'd0;
      r_up_q   <= 1'b0;
      r_dn_q   <= 1'b0;
      r_sel_q  <= 1'b0;
      r_mode_q <= 1'b0;
    end else begin
      r_up_q   <= btn_up;
      r_dn_q   <= btn_down;
      r_sel_q  <= btn_select;
      r_mode_q <= mode;
      if (w_commit) begin
        r_entry[r_count[2:0]] <= {guess0, guess1, guess2, guess3};
        r_count  <= r_count + 4'd1;
        r_cursor <= r_count[2:0];
      end else if (w_mode_fall) begin
        r_cursor <= w_newest;
      end else if (mode) begin
        if (w_up_e && !w_dn_e && w_can_up) begin
          r_cursor <= r_cursor + 3'd1;
        end else if (w_dn_e && !w_up_e && w_can_dn) begin
          r_cursor <= r_cursor - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_history.sv
// Directed self-checking bench for the history block.
// Each step drives inputs, clocks once, then checks the display.
module tb_history;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic       btn_up;
  logic       btn_down;
  logic       btn_select;
  logic [2:0] guess0;
  logic [2:0] guess1;
  logic [2:0] guess2;
  logic [2:0] guess3;
  logic [2:0] selection0;
  logic [2:0] selection1;
  logic [2:0] selection2;
  logic [2:0] selection3;
  logic [2:0] selected_turn;
  logic       last_turn;

  int n_checks = 0;
  int n_fail   = 0;

  history #(.MAX_TURNS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_select   (btn_select),
    .guess0       (guess0),
    .guess1       (guess1),
    .guess2       (guess2),
    .guess3       (guess3),
    .selection0   (selection0),
    .selection1   (selection1),
    .selection2   (selection2),
    .selection3   (selection3),
    .selected_turn(selected_turn),
    .last_turn    (last_turn)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_guess(input logic [11:0] g);
    {guess0, guess1, guess2, guess3} = g;
  endtask

  function automatic logic [11:0] ent(input int k);
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] c;
    logic [2:0] d;
    a = 3'(k);
    b = 3'(7 - k);
    c = 3'(k ^ 5);
    d = 3'(k + 3);
    return {a, b, c, d};
  endfunction

  task automatic chk(input string tag, input logic [11:0] sel,
                     input logic [2:0] turn, input logic last);
    logic [11:0] obs;
    obs = {selection0, selection1, selection2, selection3};
    n_checks++;
    assert (obs === sel) else begin
      n_fail++;
      $error("FAIL %s selection got %h want %h", tag, obs, sel);
    end
    n_checks++;
    assert (selected_turn === turn) else begin
      n_fail++;
      $error("FAIL %s turn got %0d want %0d", tag, selected_turn, turn);
    end
    n_checks++;
    assert (last_turn === last) else begin
      n_fail++;
      $error("FAIL %s last got %b want %b", tag, last_turn, last);
    end
  endtask

  task automatic commit(input logic [11:0] g);
    set_guess(g);
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    tick();
  endtask

  task automatic press_dn();
    btn_down = 1'b1;
    tick();
    btn_down = 1'b0;
    tick();
  endtask

  localparam logic [11:0] G0 = {3'd1, 3'd0, 3'd0, 3'd0};
  localparam logic [11:0] G1 = {3'd0, 3'd1, 3'd0, 3'd0};

  initial begin
    reset = 1'b1;
    mode = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_select = 1'b0;
    set_guess(12'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("reset", 12'd0, 3'd0, 1'b0);

    mode = 1'b1;
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    mode = 1'b0;
    tick();
    chk("up_empty", 12'd0, 3'd0, 1'b0);

    set_guess(G0);
    btn_select = 1'b1;
    tick();
    chk("commit0", G0, 3'd0, 1'b0);
    btn_select = 1'b0;
    mode = 1'b1;
    tick();
    mode = 1'b0;
    tick();
    tick();
    chk("mode_toggle", G0, 3'd0, 1'b0);

    commit(G1);
    chk("commit1", G1, 3'd1, 1'b0);
    mode = 1'b1;
    tick();
    chk("browse_in", G1, 3'd1, 1'b0);
    btn_down = 1'b1;
    tick();
    chk("down_step", G0, 3'd0, 1'b0);
    tick();
    tick();
    tick();
    chk("down_held", G0, 3'd0, 1'b0);
    btn_down = 1'b0;
    tick();
    press_dn();
    chk("down_floor", G0, 3'd0, 1'b0);
    btn_up = 1'b1;
    tick();
    chk("up_step", G1, 3'd1, 1'b0);
    tick();
    tick();
    chk("up_ceiling", G1, 3'd1, 1'b0);
    btn_up = 1'b0;

    set_guess(ent(6));
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    mode = 1'b0;
    tick();
    tick();
    chk("sel_in_browse", G1, 3'd1, 1'b0);

    for (int k = 2; k < 7; k++) begin
      commit(ent(k));
    end
    chk("seven", ent(6), 3'd6, 1'b0);
    set_guess(ent(7));
    btn_select = 1'b1;
    tick();
    chk("eighth", ent(7), 3'd7, 1'b1);
    btn_select = 1'b0;
    tick();
    commit(ent(1));
    chk("ninth_ignored", ent(7), 3'd7, 1'b1);

    press_dn();
    chk("down_mode0", ent(7), 3'd7, 1'b1);

    mode = 1'b1;
    tick();
    for (int k = 6; k >= 3; k--) begin
      press_dn();
      chk($sformatf("walk%0d", k), ent(k), 3'(k), 1'b1);
    end
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick();
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick();
    chk("up_and_down", ent(3), 3'd3, 1'b1);

    reset = 1'b1;
    mode = 1'b0;
    tick();
    reset = 1'b0;
    chk("mid_reset", 12'd0, 3'd0, 1'b0);
    commit({3'd2, 3'd3, 3'd4, 3'd5});
    chk("post_reset", {3'd2, 3'd3, 3'd4, 3'd5}, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
